// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage data-memory access sequencer.
// Checks load/store alignment, drives a req/ack memory port with byte
// enables and lane-replicated store data, and stalls the pipeline until the
// access completes or times out. The raw read word and byte offset go to the
// load extension unit; no sign/zero extension happens here.
module dm_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  byte_off,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic        r_done;
    logic        r_bus_err;
    logic        r_dm_req;
    logic        r_dm_we;
    logic [3:0]  r_dm_be;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_byte_off;

    logic        w_any_op;
    logic        w_aligned;
    logic        w_start;
    logic        w_misal;
    logic        w_timeout;

    // Byte enables for a size/offset pair; size 3 behaves as a word.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data across every lane it may land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'd0:    d = {4{wd[7:0]}};
            2'd1:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Alignment decode: bytes always aligned, halves need addr[0]=0, words addr[1:0]=0.
    always_comb begin
        w_aligned = 1'b1;
        case (mem_size)
            2'd0:    w_aligned = 1'b1;
            2'd1:    w_aligned = (addr[0] == 1'b0);
            default: w_aligned = (addr[1:0] == 2'b00);
        endcase
    end

    assign w_any_op  = mem_rd | mem_wr;
    assign w_start   = w_any_op & w_aligned;
    assign w_misal   = w_any_op & ~w_aligned;
    assign w_timeout = (r_state == ST_ACCESS) && !dm_ack &&
                       (r_cnt == CNT_W'(TIMEOUT - 1));

    // Next-state logic for the IDLE -> ACCESS -> DONE sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_next_state = ST_ACCESS;
                else         w_next_state = ST_IDLE;
            end
            ST_ACCESS: begin
                if (dm_ack || w_timeout) w_next_state = ST_DONE;
                else                     w_next_state = ST_ACCESS;
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Access datapath: launch the request, hold it stable, capture read data or time out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_bus_err  <= 1'b0;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_be    <= 4'b0000;
            r_dm_addr  <= 32'h0000_0000;
            r_dm_wdata <= 32'h0000_0000;
            r_rdata    <= 32'h0000_0000;
            r_byte_off <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done    <= 1'b0;
                    r_bus_err <= 1'b0;
                    if (w_start) begin
                        r_dm_req   <= 1'b1;
                        r_dm_we    <= mem_wr;
                        r_dm_be    <= lane_be(mem_size, addr[1:0]);
                        r_dm_addr  <= {addr[31:2], 2'b00};
                        r_dm_wdata <= mem_wr ? lane_wdata(mem_size, wdata) : 32'h0000_0000;
                        r_byte_off <= addr[1:0];
                        r_cnt      <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (dm_ack) begin
                        if (!r_dm_we) r_rdata <= dm_rdata;
                        r_dm_req <= 1'b0;
                        r_done   <= 1'b1;
                    end else if (w_timeout) begin
                        r_dm_req  <= 1'b0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done    <= 1'b0;
                    r_bus_err <= 1'b0;
                end
                default: begin
                    r_dm_req  <= 1'b0;
                    r_done    <= 1'b0;
                    r_bus_err <= 1'b0;
                end
            endcase
        end
    end

    // Combinational handshakes are forced low while reset is held so the pipeline releases at once.
    assign stall    = reset & (((r_state == ST_IDLE) & w_start) | (r_state == ST_ACCESS));
    assign exc_adel = reset & (r_state == ST_IDLE) & w_misal & ~mem_wr;
    assign exc_ades = reset & (r_state == ST_IDLE) & w_misal & mem_wr;

    assign done     = r_done;
    assign bus_err  = r_bus_err;
    assign dm_req   = r_dm_req;
    assign dm_we    = r_dm_we;
    assign dm_be    = r_dm_be;
    assign dm_addr  = r_dm_addr;
    assign dm_wdata = r_dm_wdata;
    assign rdata    = r_rdata;
    assign byte_off = r_byte_off;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: expected memory-port fields and
// load data are queued when an access is driven and compared when the DUT
// presents the request or completes the access.
module tb_dm_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic        stall, done, exc_adel, exc_ades, bus_err;
    logic [31:0] rdata;
    logic [1:0]  byte_off;
    logic        dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ack;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        sb_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] exp_rdata = 32'h0;

    dm_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_size(mem_size), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .byte_off(byte_off),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0)      return 4'b0001 << a[1:0];
        else if (sz == 2'd1) return (a[1] == 1'b1) ? 4'b1100 : 4'b0011;
        else                 return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0)      return {d[7:0], d[7:0], d[7:0], d[7:0]};
        else if (sz == 2'd1) return {d[15:0], d[15:0]};
        else                 return d;
    endfunction

    task automatic idle_inputs();
        mem_rd = 1'b0; mem_wr = 1'b0; mem_size = 2'd0;
        addr = 32'h0; wdata = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
    endtask

    // Drives one aligned access starting in IDLE; ack_at<0 means never acknowledge.
    task automatic run_access(input string nm, input logic wr, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_at, input logic [31:0] rv);
        req_t e;
        req_t g;
        int   stall_n = 0;
        int   req_n   = 0;
        bit   seen    = 1'b0;
        bit   fin     = 1'b0;
        bit   exp_to  = (ack_at < 0);
        logic [31:0] er;
        e.we = wr; e.be = model_be(sz, a); e.addr = {a[31:2], 2'b00};
        e.wdata = wr ? model_wd(sz, wd) : 32'h0;
        sb_q.push_back(e);
        if (!wr) rd_q.push_back(rv);
        mem_rd = ~wr; mem_wr = wr; mem_size = sz; addr = a; wdata = wd;
        for (int k = 0; k < 60 && !fin; k++) begin
            #1;
            if (stall) stall_n++;
            if (dm_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    g = sb_q.pop_front();
                    n_vec++;
                    if (dm_we !== g.we || dm_be !== g.be || dm_addr !== g.addr || dm_wdata !== g.wdata) begin
                        n_err++;
                        $display("FAIL %s req: we=%b be=%b addr=%h wd=%h, want we=%b be=%b addr=%h wd=%h",
                                 nm, dm_we, dm_be, dm_addr, dm_wdata, g.we, g.be, g.addr, g.wdata);
                    end
                end
                if (req_n == ack_at) begin dm_ack = 1'b1; dm_rdata = rv; end
                req_n++;
            end else if (done || bus_err) begin
                fin = 1'b1;
                n_vec++;
                if (done !== !exp_to || bus_err !== exp_to || stall !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s end: done=%b bus_err=%b stall=%b, want done=%b bus_err=%b stall=0",
                             nm, done, bus_err, stall, !exp_to, exp_to);
                end
                n_vec++;
                if (stall_n != (exp_to ? TIMEOUT + 1 : ack_at + 2) || req_n != (exp_to ? TIMEOUT : ack_at + 1)) begin
                    n_err++;
                    $display("FAIL %s timing: stall_cycles=%0d req_cycles=%0d, want %0d %0d", nm, stall_n, req_n,
                             exp_to ? TIMEOUT + 1 : ack_at + 2, exp_to ? TIMEOUT : ack_at + 1);
                end
                if (!wr) begin
                    er = rd_q.pop_front();
                    if (!exp_to) exp_rdata = er;
                end
                n_vec++;
                if (rdata !== exp_rdata || byte_off !== a[1:0]) begin
                    n_err++;
                    $display("FAIL %s data: rdata=%h byte_off=%0d, want rdata=%h byte_off=%0d",
                             nm, rdata, byte_off, exp_rdata, a[1:0]);
                end
            end
            @(negedge clk);
            dm_ack = 1'b0;
        end
        if (!fin) begin
            n_vec++; n_err++;
            $display("FAIL %s wait: access never completed, want done or bus_err", nm);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({stall, done, exc_adel, exc_ades, bus_err, dm_req, dm_we} !== 7'b0 ||
            dm_be !== 4'h0 || dm_addr !== 32'h0 || dm_wdata !== 32'h0 || rdata !== 32'h0 || byte_off !== 2'd0) begin
            n_err++;
            $display("FAIL reset: stall=%b done=%b req=%b be=%h addr=%h rdata=%h, want all zero",
                     stall, done, dm_req, dm_be, dm_addr, rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loads();
        run_access("lw_wait", 1'b0, 2'd2, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF);
        run_access("lb_off3", 1'b0, 2'd0, 32'h0000_0107, 32'h0, 0, 32'h1122_3344);
        run_access("lh_hi",   1'b0, 2'd1, 32'h0000_0202, 32'h0, 3, 32'hCAFE_F00D);
        run_access("lw_sz3",  1'b0, 2'd3, 32'h0000_0300, 32'h0, 0, 32'h0BAD_1DEA);
    endtask

    task automatic test_stores();
        run_access("sb_23",  1'b1, 2'd0, 32'h0000_0023, 32'h0000_00A5, 0, 32'hFFFF_FFFF);
        run_access("sh_12",  1'b1, 2'd1, 32'h0000_0012, 32'h0000_1234, 2, 32'h0);
        run_access("sh_lo",  1'b1, 2'd1, 32'h0000_0040, 32'hFFFF_5A5A, 0, 32'h0);
        run_access("sw_44",  1'b1, 2'd2, 32'h0000_0044, 32'h8765_4321, 1, 32'h0);
    endtask

    task automatic test_misaligned();
        mem_rd = 1'b1; mem_size = 2'd1; addr = 32'h0000_0011;
        #1;
        n_vec++;
        if (exc_adel !== 1'b1 || exc_ades !== 1'b0 || stall !== 1'b0 || dm_req !== 1'b0) begin
            n_err++;
            $display("FAIL lh_misal: adel=%b ades=%b stall=%b req=%b, want 1 0 0 0", exc_adel, exc_ades, stall, dm_req);
        end
        @(negedge clk);
        idle_inputs();
        mem_wr = 1'b1; mem_size = 2'd2; addr = 32'h0000_0006; wdata = 32'h1;
        #1;
        n_vec++;
        if (exc_ades !== 1'b1 || exc_adel !== 1'b0 || stall !== 1'b0 || dm_req !== 1'b0) begin
            n_err++;
            $display("FAIL sw_misal: adel=%b ades=%b stall=%b req=%b, want 0 1 0 0", exc_adel, exc_ades, stall, dm_req);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_vec++;
        if (dm_req !== 1'b0 || exc_ades !== 1'b0 || exc_adel !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL misal_after: req=%b ades=%b adel=%b stall=%b, want all 0", dm_req, exc_ades, exc_adel, stall);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        run_access("lw_timeout", 1'b0, 2'd2, 32'h0000_0080, 32'h0, -1, 32'h5555_5555);
    endtask

    task automatic test_reset_mid();
        mem_rd = 1'b1; mem_size = 2'd2; addr = 32'h0000_0050;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        exp_rdata = 32'h0;
        n_vec++;
        if (dm_req !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: req=%b stall=%b, want 0 0", dm_req, stall);
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (done !== 1'b0 || dm_req !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_after: done=%b req=%b, want 0 0", done, dm_req);
            end
        end
        @(negedge clk);
        run_access("lw_after_rst", 1'b0, 2'd2, 32'h0000_0054, 32'h0, 0, 32'h0F0F_0F0F);
    endtask

    task automatic test_back_to_back();
        // lw then sw held on the inputs; DONE must ignore the sw and IDLE must relaunch it.
        mem_rd = 1'b1; mem_size = 2'd2; addr = 32'h0000_0060;
        @(negedge clk);                         // ACCESS
        dm_ack = 1'b1; dm_rdata = 32'hA1B2_C3D4;
        @(negedge clk);                         // DONE
        dm_ack = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b1; addr = 32'h0000_0068; wdata = 32'h0101_0202;
        #1;
        exp_rdata = 32'hA1B2_C3D4;
        n_vec++;
        if (done !== 1'b1 || stall !== 1'b0 || dm_req !== 1'b0 || rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL b2b_done: done=%b stall=%b req=%b rdata=%h, want 1 0 0 %h", done, stall, dm_req, rdata, exp_rdata);
        end
        @(negedge clk);                         // IDLE again with sw pending
        #1;
        n_vec++;
        if (stall !== 1'b1 || dm_req !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: stall=%b req=%b done=%b, want 1 0 0", stall, dm_req, done);
        end
        @(negedge clk);                         // ACCESS for sw
        #1;
        n_vec++;
        if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_addr !== 32'h0000_0068 || dm_be !== 4'hF || dm_wdata !== 32'h0101_0202) begin
            n_err++;
            $display("FAIL b2b_sw: req=%b we=%b addr=%h be=%h wd=%h, want 1 1 00000068 f 01010202",
                     dm_req, dm_we, dm_addr, dm_be, dm_wdata);
        end
        dm_ack = 1'b1;
        @(negedge clk);                         // DONE
        idle_inputs();
        #1;
        n_vec++;
        if (done !== 1'b1 || rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL b2b_sw_done: done=%b rdata=%h, want 1 %h", done, rdata, exp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_stray_ack();
        dm_ack = 1'b1; dm_rdata = 32'h7777_7777;
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        n_vec++;
        if (done !== 1'b0 || dm_req !== 1'b0 || stall !== 1'b0 || rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL stray_ack: done=%b req=%b stall=%b rdata=%h, want 0 0 0 %h", done, dm_req, stall, rdata, exp_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_stray_ack();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
